// File: rtl/sdram_memtest_pkg.sv
// Shared types and AXI/LFSR constants for the SDRAM AXI memory tester.
package sdram_memtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_FIN
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

endpackage

// File: rtl/sdram_axi_memtest_lfsr.sv
// 32-bit right-shifting Galois LFSR; reloaded between the write and read passes.
module memtest_lfsr
  import sdram_memtest_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] value
);

  logic [31:0] value_q, value_d;

  // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (step) begin
      value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_TAPS : 32'h0);
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARST) value_q <= '0;
    else      value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/sdram_axi_memtest.sv
// AXI4 write-then-readback memory tester for sdram_axi bring-up.
// Define MEMTEST_ADDR_PATTERN_EN to use each beat's byte address as data instead of the LFSR.
module sdram_axi_memtest
  import sdram_memtest_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          TEST_WORDS = 1024,
  parameter int          BURST_LEN  = 16,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr,

  output logic        M_AXI_awvalid,
  input  logic        M_AXI_awready,
  output logic [31:0] M_AXI_awaddr,
  output logic [7:0]  M_AXI_awlen,
  output logic [1:0]  M_AXI_awburst,
  output logic [2:0]  M_AXI_awsize,

  output logic        M_AXI_wvalid,
  input  logic        M_AXI_wready,
  output logic [31:0] M_AXI_wdata,
  output logic [3:0]  M_AXI_wstrb,
  output logic        M_AXI_wlast,

  input  logic        M_AXI_bvalid,
  output logic        M_AXI_bready,
  input  logic [1:0]  M_AXI_bresp,

  output logic        M_AXI_arvalid,
  input  logic        M_AXI_arready,
  output logic [31:0] M_AXI_araddr,
  output logic [7:0]  M_AXI_arlen,
  output logic [1:0]  M_AXI_arburst,
  output logic [2:0]  M_AXI_arsize,

  input  logic        M_AXI_rvalid,
  output logic        M_AXI_rready,
  input  logic [31:0] M_AXI_rdata,
  input  logic [1:0]  M_AXI_rresp,
  input  logic        M_AXI_rlast
);

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [31:0] LAST_ADDR   = BASE_ADDR + 32'((TEST_WORDS - BURST_LEN) * 4);

  if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_err_burst_len
    $error("BURST_LEN must be in 1..256");
  end
  if (TEST_WORDS % BURST_LEN != 0) begin : g_err_test_words
    $error("TEST_WORDS must be a multiple of BURST_LEN");
  end
  if (BASE_ADDR % BURST_BYTES != 32'd0) begin : g_err_base_addr
    $error("BASE_ADDR must be aligned to BURST_LEN*4");
  end
  if (SEED == 32'd0) begin : g_err_seed
    $error("SEED must be nonzero");
  end

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [31:0] first_q, first_d;

  logic [31:0] beat_addr;
  logic [31:0] pattern;
  logic        w_fire, r_fire, last_beat, last_burst;
  logic        beat_err;
  logic [31:0] err_addr;

  assign beat_addr  = addr_q + (32'(beat_q) << 2);
  assign w_fire     = (state_q == ST_W) && M_AXI_wready;
  assign r_fire     = (state_q == ST_R) && M_AXI_rvalid;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_burst = (addr_q == LAST_ADDR);

`ifdef MEMTEST_ADDR_PATTERN_EN
  assign pattern = beat_addr;
`else
  logic        lfsr_load, lfsr_step;
  logic [31:0] lfsr_value;

  // Reload at start and again at the write-to-read turnaround so both passes see one sequence.
  assign lfsr_load = ((state_q == ST_IDLE) && start) ||
                     ((state_q == ST_B) && M_AXI_bvalid && last_burst);
  assign lfsr_step = w_fire || r_fire;

  memtest_lfsr u_lfsr (
    .ACLK  (ACLK),
    .ARST  (ARST),
    .load  (lfsr_load),
    .seed  (SEED),
    .step  (lfsr_step),
    .value (lfsr_value)
  );

  assign pattern = lfsr_value;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beat_d    = beat_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_cnt_d = err_cnt_q;
    first_d   = first_q;
    beat_err  = 1'b0;
    err_addr  = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_AW;
          addr_d    = BASE_ADDR;
          beat_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_cnt_d = '0;
          first_d   = '0;
        end
      end
      ST_AW: if (M_AXI_awready) state_d = ST_W;
      ST_W: begin
        if (w_fire) begin
          beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
          if (last_beat) state_d = ST_B;
        end
      end
      ST_B: begin
        if (M_AXI_bvalid) begin
          beat_err = (M_AXI_bresp != AXI_RESP_OKAY);
          if (last_burst) begin
            addr_d  = BASE_ADDR;
            state_d = ST_AR;
          end else begin
            addr_d  = addr_q + BURST_BYTES;
            state_d = ST_AW;
          end
        end
      end
      ST_AR: if (M_AXI_arready) state_d = ST_R;
      ST_R: begin
        if (r_fire) begin
          err_addr = beat_addr;
          beat_err = (M_AXI_rdata != pattern) || (M_AXI_rresp != AXI_RESP_OKAY) ||
                     (M_AXI_rlast != last_beat);
          if (last_beat) begin
            beat_d  = '0;
            addr_d  = addr_q + BURST_BYTES;
            state_d = last_burst ? ST_FIN : ST_AR;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // First failure address is captured only while the count is still zero.
    if (beat_err) begin
      if (err_cnt_q == 16'd0)     first_d   = err_addr;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      beat_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_cnt_q <= '0;
      first_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beat_q    <= beat_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
      first_q   <= first_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = (err_cnt_q != 16'd0);
  assign err_count      = err_cnt_q;
  assign first_err_addr = first_q;

  assign M_AXI_awvalid = (state_q == ST_AW);
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_awlen   = LAST_BEAT;
  assign M_AXI_awburst = AXI_BURST_INCR;
  assign M_AXI_awsize  = AXI_SIZE_4B;

  assign M_AXI_wvalid  = (state_q == ST_W);
  assign M_AXI_wdata   = pattern;
  assign M_AXI_wstrb   = 4'hF;
  assign M_AXI_wlast   = last_beat;

  assign M_AXI_bready  = (state_q == ST_B);

  assign M_AXI_arvalid = (state_q == ST_AR);
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_arlen   = LAST_BEAT;
  assign M_AXI_arburst = AXI_BURST_INCR;
  assign M_AXI_arsize  = AXI_SIZE_4B;

  assign M_AXI_rready  = (state_q == ST_R);

endmodule

// File: tb/tb_sdram_axi_memtest.sv
// Bench for sdram_axi_memtest: AXI slave BFM with fault/stall injection and a reference model.
module tb_sdram_axi_memtest;

`ifdef MEMTEST_ADDR_PATTERN_EN
  localparam logic [31:0] BASE = 32'h0000_0100;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif
  localparam int          TW   = 64;
  localparam int          BL   = 16;
  localparam int          NB   = TW / BL;
  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  logic        M_AXI_awvalid, M_AXI_awready;
  logic [31:0] M_AXI_awaddr;
  logic [7:0]  M_AXI_awlen;
  logic [1:0]  M_AXI_awburst;
  logic [2:0]  M_AXI_awsize;
  logic        M_AXI_wvalid, M_AXI_wready, M_AXI_wlast;
  logic [31:0] M_AXI_wdata;
  logic [3:0]  M_AXI_wstrb;
  logic        M_AXI_bvalid, M_AXI_bready;
  logic [1:0]  M_AXI_bresp;
  logic        M_AXI_arvalid, M_AXI_arready;
  logic [31:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [1:0]  M_AXI_arburst;
  logic [2:0]  M_AXI_arsize;
  logic        M_AXI_rvalid, M_AXI_rready, M_AXI_rlast;
  logic [31:0] M_AXI_rdata;
  logic [1:0]  M_AXI_rresp;

  always #5 ACLK = ~ACLK;

  sdram_axi_memtest #(
    .BASE_ADDR  (BASE),
    .TEST_WORDS (TW),
    .BURST_LEN  (BL),
    .SEED       (SEED)
  ) dut (
    .ACLK           (ACLK),
    .ARST           (ARST),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .M_AXI_awvalid  (M_AXI_awvalid),
    .M_AXI_awready  (M_AXI_awready),
    .M_AXI_awaddr   (M_AXI_awaddr),
    .M_AXI_awlen    (M_AXI_awlen),
    .M_AXI_awburst  (M_AXI_awburst),
    .M_AXI_awsize   (M_AXI_awsize),
    .M_AXI_wvalid   (M_AXI_wvalid),
    .M_AXI_wready   (M_AXI_wready),
    .M_AXI_wdata    (M_AXI_wdata),
    .M_AXI_wstrb    (M_AXI_wstrb),
    .M_AXI_wlast    (M_AXI_wlast),
    .M_AXI_bvalid   (M_AXI_bvalid),
    .M_AXI_bready   (M_AXI_bready),
    .M_AXI_bresp    (M_AXI_bresp),
    .M_AXI_arvalid  (M_AXI_arvalid),
    .M_AXI_arready  (M_AXI_arready),
    .M_AXI_araddr   (M_AXI_araddr),
    .M_AXI_arlen    (M_AXI_arlen),
    .M_AXI_arburst  (M_AXI_arburst),
    .M_AXI_arsize   (M_AXI_arsize),
    .M_AXI_rvalid   (M_AXI_rvalid),
    .M_AXI_rready   (M_AXI_rready),
    .M_AXI_rdata    (M_AXI_rdata),
    .M_AXI_rresp    (M_AXI_rresp),
    .M_AXI_rlast    (M_AXI_rlast)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference data sequence, built from the pattern rule rather than from the DUT.
  logic [31:0] exp_seq [TW];

  function automatic logic [31:0] lfsr_ref(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Slave configuration (written by the stimulus only).
  bit stall_en = 1'b0;
  bit flip_en  = 1'b0;
  int bresp_err_burst = -1;
  int rresp_err_beat  = -1;

  // Slave state and logs.
  logic [31:0] mem [TW];
  logic [31:0] aw_log[$], ar_log[$], w_log[$];
  int          fixed_bad = 0, wlast_bad = 0;
  logic [31:0] wr_addr = '0, rd_addr = '0, sa;
  int          wr_beat = 0, rd_beat = 0, rd_left = 0;
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit          b_pend = 1'b0, b_fire = 1'b0, r_fire = 1'b0;

  function automatic int stall();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Every decision is taken on the falling edge; a ready/valid raised here meets its
  // partner at the next rising edge, so the beat is logged at the moment it is granted.
  always @(negedge ACLK) begin
    if (ARST) begin
      M_AXI_awready = 1'b0; M_AXI_wready = 1'b0; M_AXI_arready = 1'b0;
      M_AXI_bvalid = 1'b0;  M_AXI_bresp = 2'b00;
      M_AXI_rvalid = 1'b0;  M_AXI_rdata = '0; M_AXI_rresp = 2'b00; M_AXI_rlast = 1'b0;
      b_pend = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
      wr_beat = 0; rd_beat = 0; rd_left = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      if (b_fire) begin M_AXI_bvalid = 1'b0; b_fire = 1'b0; end
      if (b_pend && !M_AXI_bvalid) begin
        if (b_wait > 0) b_wait--;
        else begin
          M_AXI_bvalid = 1'b1;
          M_AXI_bresp  = (widx(wr_addr) / BL == bresp_err_burst) ? 2'b10 : 2'b00;
          b_pend = 1'b0;
          b_wait = stall();
        end
      end
      if (M_AXI_bvalid && M_AXI_bready) b_fire = 1'b1;

      if (r_fire) begin M_AXI_rvalid = 1'b0; r_fire = 1'b0; end
      if (rd_left > 0 && !M_AXI_rvalid) begin
        if (r_wait > 0) r_wait--;
        else begin
          sa = rd_addr + 32'(rd_beat * 4);
          M_AXI_rdata = mem[widx(sa)];
          if (flip_en && sa == BASE + 32'h44) M_AXI_rdata[0] = ~M_AXI_rdata[0];
          M_AXI_rresp  = (widx(sa) == rresp_err_beat) ? 2'b10 : 2'b00;
          M_AXI_rlast  = (rd_beat == BL - 1);
          M_AXI_rvalid = 1'b1;
          rd_beat++;
          rd_left--;
          r_wait = stall();
        end
      end
      if (M_AXI_rvalid && M_AXI_rready) r_fire = 1'b1;

      M_AXI_awready = 1'b0;
      if (M_AXI_awvalid) begin
        if (aw_wait > 0) aw_wait--;
        else begin
          M_AXI_awready = 1'b1;
          wr_addr = M_AXI_awaddr;
          wr_beat = 0;
          aw_log.push_back(M_AXI_awaddr);
          if (M_AXI_awlen != 8'(BL - 1) || M_AXI_awburst != 2'b01 || M_AXI_awsize != 3'b010)
            fixed_bad++;
          aw_wait = stall();
        end
      end

      M_AXI_wready = 1'b0;
      if (M_AXI_wvalid) begin
        if (w_wait > 0) w_wait--;
        else begin
          M_AXI_wready = 1'b1;
          w_log.push_back(M_AXI_wdata);
          mem[widx(wr_addr + 32'(wr_beat * 4))] = M_AXI_wdata;
          if (M_AXI_wstrb != 4'hF) fixed_bad++;
          if (M_AXI_wlast != (wr_beat == BL - 1)) wlast_bad++;
          if (wr_beat == BL - 1) begin b_pend = 1'b1; wr_beat = 0; end
          else wr_beat++;
          w_wait = stall();
        end
      end

      M_AXI_arready = 1'b0;
      if (M_AXI_arvalid && rd_left == 0 && !M_AXI_rvalid) begin
        if (ar_wait > 0) ar_wait--;
        else begin
          M_AXI_arready = 1'b1;
          rd_addr = M_AXI_araddr;
          rd_beat = 0;
          rd_left = int'(M_AXI_arlen) + 1;
          ar_log.push_back(M_AXI_araddr);
          if (M_AXI_arlen != 8'(BL - 1) || M_AXI_arburst != 2'b01 || M_AXI_arsize != 3'b010)
            fixed_bad++;
          ar_wait = stall();
        end
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 20000) begin
      tick();
      c++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic run_test(input string tag, input bit stalls, input bit flip,
                          input int b_err, input int r_err, input bit poke);
    int          w0, aw0, ar0, fb0, wl0, exp_cnt;
    logic [31:0] exp_first, a;
    stall_en = stalls; flip_en = flip; bresp_err_burst = b_err; rresp_err_beat = r_err;
    w0 = w_log.size(); aw0 = aw_log.size(); ar0 = ar_log.size();
    fb0 = fixed_bad; wl0 = wlast_bad;

    pulse_start();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (poke) begin
      repeat (3) tick();
      pulse_start();
    end
    wait_done(tag);

    // Expected outcome: bad write responses in burst order, then faulty read beats in address order.
    exp_cnt = 0; exp_first = '0;
    for (int b = 0; b < NB; b++) begin
      if (b == b_err) begin
        if (exp_cnt == 0) exp_first = BASE + 32'(b * BL * 4);
        exp_cnt++;
      end
    end
    for (int i = 0; i < TW; i++) begin
      a = BASE + 32'(i * 4);
      if ((flip && a == BASE + 32'h44) || i == r_err) begin
        if (exp_cnt == 0) exp_first = a;
        exp_cnt++;
      end
    end

    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_error"}, 32'(error), 32'(exp_cnt != 0));
    check({tag, "_err_count"}, 32'(err_count), 32'(exp_cnt));
    check({tag, "_first_err_addr"}, first_err_addr, exp_first);
    check({tag, "_aw_count"}, 32'(aw_log.size() - aw0), 32'(NB));
    check({tag, "_ar_count"}, 32'(ar_log.size() - ar0), 32'(NB));
    check({tag, "_w_count"}, 32'(w_log.size() - w0), 32'(TW));
    for (int b = 0; b < NB; b++) begin
      check({tag, "_awaddr"}, aw_log[aw0 + b], BASE + 32'(b * BL * 4));
      check({tag, "_araddr"}, ar_log[ar0 + b], BASE + 32'(b * BL * 4));
    end
    for (int i = 0; i < TW; i++) check({tag, "_wdata"}, w_log[w0 + i], exp_seq[i]);
    check({tag, "_fixed_fields"}, 32'(fixed_bad - fb0), 32'd0);
    check({tag, "_wlast"}, 32'(wlast_bad - wl0), 32'd0);
  endtask

  initial begin
    int          w0, c;
    logic [31:0] v;

    v = SEED;
    for (int i = 0; i < TW; i++) begin
`ifdef MEMTEST_ADDR_PATTERN_EN
      exp_seq[i] = BASE + 32'(i * 4);
`else
      exp_seq[i] = v;
`endif
      v = lfsr_ref(v);
    end

    ARST = 1'b1;
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_first_err_addr", first_err_addr, 32'd0);
    check("reset_valids", {27'd0, M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid,
                           M_AXI_bready, M_AXI_rready}, 32'd0);
    ARST = 1'b0;
    tick();

    run_test("clean", 1'b0, 1'b0, -1, -1, 1'b0);
    run_test("flip44", 1'b0, 1'b1, -1, -1, 1'b0);
    run_test("stalls", 1'b1, 1'b0, -1, -1, 1'b0);
    run_test("resp_err", 1'b1, 1'b0, 1, 40, 1'b0);

    // Abandon a test mid-burst: bad bresp on burst 0 leaves sticky state to be cleared.
    stall_en = 1'b0; flip_en = 1'b0; bresp_err_burst = 0; rresp_err_beat = -1;
    w0 = w_log.size();
    pulse_start();
    c = 0;
    while (w_log.size() - w0 < BL + 7 && c < 5000) begin
      tick();
      c++;
    end
    check("midrst_reached_beat7", 32'(w_log.size() - w0), 32'(BL + 7));
    check("midrst_pre_err_count", 32'(err_count), 32'd1);
    ARST = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_first_err_addr", first_err_addr, 32'd0);
    check("midrst_valids", {27'd0, M_AXI_awvalid, M_AXI_wvalid, M_AXI_arvalid,
                            M_AXI_bready, M_AXI_rready}, 32'd0);
    ARST = 1'b0;
    tick();
    run_test("rerun", 1'b0, 1'b0, -1, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
